// File: rtl/rx_preamble_sfd_detector_if.sv
// rx_preamble_sfd_detector_if: GMII-style PHY receive bus plus the stripped-frame and statistics outputs
interface rx_preamble_sfd_detector_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 phy_rx_dv;
  logic [7:0]           phy_rxd;
  logic                 phy_rx_er;
  logic                 rx_en;
  logic [7:0]           rx_data;
  logic                 rx_data_valid;
  logic                 rx_sof;
  logic                 rx_eof;
  logic                 rx_err;
  logic [15:0]          frame_len;
  logic [CNT_WIDTH-1:0] stat_good;
  logic [CNT_WIDTH-1:0] stat_bad;
  logic [CNT_WIDTH-1:0] stat_align_err;
  modport master (
    output phy_rx_dv, phy_rxd, phy_rx_er,
    input  rx_en, rx_data, rx_data_valid, rx_sof, rx_eof, rx_err, frame_len,
    input  stat_good, stat_bad, stat_align_err
  );
  modport slave (
    input  phy_rx_dv, phy_rxd, phy_rx_er,
    output rx_en, rx_data, rx_data_valid, rx_sof, rx_eof, rx_err, frame_len,
    output stat_good, stat_bad, stat_align_err
  );
endinterface

// File: rtl/rx_preamble_sfd_detector.sv
// rx_preamble_sfd_detector: hunts 0x55 preamble + 0xD5 SFD, strips them and forwards frame bytes
// through a one-byte hold register so the last byte can carry rx_eof; keeps saturating frame statistics.
module rx_preamble_sfd_detector #(
  parameter int MIN_PREAMBLE  = 1,
  parameter int MAX_PREAMBLE  = 7,
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int CNT_WIDTH     = 16
) (
  input logic                       clk,
  input logic                       rst_n,
  rx_preamble_sfd_detector_if.slave bus
);
  typedef enum logic [1:0] {DROP, IDLE, PRE, DATA} state_t;
  localparam int PW = $clog2(MAX_PREAMBLE + 1);
  localparam logic [PW-1:0] MIN_P = PW'(MIN_PREAMBLE);
  localparam logic [PW-1:0] MAX_P = PW'(MAX_PREAMBLE);
  localparam logic [15:0] MIN_L = 16'(MIN_FRAME_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_FRAME_LEN);
  state_t               state_q, state_d;
  logic [PW-1:0]        pcnt_q, pcnt_d;
  logic [7:0]           hold_q, hold_d;
  logic                 hold_v_q, hold_v_d;
  logic                 first_q, first_d;
  logic                 bad_q, bad_d;
  logic [15:0]          blen_q, blen_d;
  logic                 en_q, en_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 sof_q, sof_d;
  logic                 eof_q, eof_d;
  logic                 err_q, err_d;
  logic [15:0]          len_q, len_d;
  logic [CNT_WIDTH-1:0] sg_q, sg_d, sb_q, sb_d, sa_q, sa_d;
  logic                 dv, er, is_55, is_d5, go_pre, pre_more, sfd, align;
  logic                 oversize, eof, emit, load, frame_bad;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DROP;
      pcnt_q   <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      first_q  <= 1'b0;
      bad_q    <= 1'b0;
      blen_q   <= '0;
      en_q     <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      err_q    <= 1'b0;
      len_q    <= '0;
      sg_q     <= '0;
      sb_q     <= '0;
      sa_q     <= '0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      first_q  <= first_d;
      bad_q    <= bad_d;
      blen_q   <= blen_d;
      en_q     <= en_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      err_q    <= err_d;
      len_q    <= len_d;
      sg_q     <= sg_d;
      sb_q     <= sb_d;
      sa_q     <= sa_d;
    end
  end
  always_comb begin
    dv        = bus.phy_rx_dv;
    er        = bus.phy_rx_er;
    is_55     = dv && !er && bus.phy_rxd == 8'h55;
    is_d5     = dv && !er && bus.phy_rxd == 8'hD5;
    go_pre    = state_q == IDLE && is_55;
    pre_more  = state_q == PRE && is_55 && pcnt_q < MAX_P;
    sfd       = state_q == PRE && is_d5 && pcnt_q >= MIN_P;
    align     = (state_q == IDLE || state_q == PRE) && dv && !(go_pre || pre_more || sfd);
    oversize  = state_q == DATA && dv && blen_q == MAX_L;
    eof       = (state_q == DATA && !dv) || oversize;
    emit      = state_q == DATA && hold_v_q;
    load      = state_q == DATA && dv && !oversize;
    // an empty hold at end of frame means nothing followed the SFD
    frame_bad = bad_q || oversize || !hold_v_q || blen_q < MIN_L;
    state_d   = (align || oversize) ? DROP : go_pre ? PRE : sfd ? DATA : !dv ? IDLE : state_q;
    pcnt_d    = go_pre ? PW'(1) : pre_more ? pcnt_q + 1'b1 : pcnt_q;
    hold_d    = load ? bus.phy_rxd : hold_q;
    hold_v_d  = load || (hold_v_q && !eof);
    first_d   = sfd || (first_q && !emit);
    bad_d     = !sfd && (bad_q || (load && er));
    blen_d    = sfd ? '0 : load ? blen_q + 16'd1 : blen_q;
  end
  always_comb begin
    en_d    = state_d == DATA || eof;
    valid_d = emit;
    data_d  = emit ? hold_q : data_q;
    sof_d   = emit && first_q;
    eof_d   = eof;
    err_d   = eof && frame_bad;
    len_d   = eof ? blen_q : '0;
    sg_d    = (eof && !frame_bad && !(&sg_q)) ? sg_q + 1'b1 : sg_q;
    sb_d    = (eof && frame_bad && !(&sb_q)) ? sb_q + 1'b1 : sb_q;
    sa_d    = (align && !(&sa_q)) ? sa_q + 1'b1 : sa_q;
  end
  assign bus.rx_en          = en_q;
  assign bus.rx_data        = data_q;
  assign bus.rx_data_valid  = valid_q;
  assign bus.rx_sof         = sof_q;
  assign bus.rx_eof         = eof_q;
  assign bus.rx_err         = err_q;
  assign bus.frame_len      = len_q;
  assign bus.stat_good      = sg_q;
  assign bus.stat_bad       = sb_q;
  assign bus.stat_align_err = sa_q;
endmodule

// File: tb/tb_rx_preamble_sfd_detector.sv
// tb_rx_preamble_sfd_detector: directed and random PHY streams checked every cycle against a
// frame-level model that places each expected output by arithmetic on burst/preamble/payload positions.
module tb_rx_preamble_sfd_detector;
  localparam int CW = 4;
  localparam int SMAX = (1 << CW) - 1;
  localparam int MAXN = 4096;
  localparam int MIN_PRE = 1, MAX_PRE = 7, MIN_LEN = 64, MAX_LEN = 1518;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  rx_preamble_sfd_detector_if #(.CNT_WIDTH(CW)) bus ();
  rx_preamble_sfd_detector #(.CNT_WIDTH(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic       s_dv [MAXN];
  logic [7:0] s_d  [MAXN];
  logic       s_er [MAXN];
  int         n;
  logic       e_en [MAXN+2], e_val [MAXN+2], e_sof [MAXN+2], e_eof [MAXN+2], e_err [MAXN+2];
  logic       ev_g [MAXN+2], ev_b [MAXN+2], ev_a [MAXN+2];
  logic [7:0] e_dat [MAXN+2];
  logic [15:0] e_len [MAXN+2];
  int         e_sg [MAXN+2], e_sb [MAXN+2], e_sa [MAXN+2];
  int         errors = 0, checks = 0;
  int         obs_val, obs_eof, obs_len;
  logic       obs_err;
  logic [7:0] obs_eof_dat;
  task automatic push(input logic v, input logic [7:0] d, input logic e);
    if (n < MAXN) begin
      s_dv[n] = v; s_d[n] = d; s_er[n] = e; n++;
    end
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) push(1'b0, 8'h00, 1'b0);
  endtask
  task automatic frame(input int npre, input int len, input int erpos, input bit rnd);
    for (int i = 0; i < npre; i++) push(1'b1, 8'h55, 1'b0);
    push(1'b1, 8'hD5, 1'b0);
    for (int j = 0; j < len; j++) push(1'b1, rnd ? 8'($urandom) : 8'(j), j == erpos);
    idle(1);
  endtask
  task automatic model();
    int c, s, e, L, i, t, nb, m, ec, g, b, a;
    bit bad;
    logic [7:0] cur;
    for (int k = 0; k < MAXN + 2; k++) begin
      e_en[k] = 0; e_val[k] = 0; e_sof[k] = 0; e_eof[k] = 0; e_err[k] = 0;
      ev_g[k] = 0; ev_b[k] = 0; ev_a[k] = 0; e_dat[k] = 0; e_len[k] = 0;
    end
    c = 0;
    while (c < n) begin
      if (!s_dv[c]) begin c++; continue; end
      s = c;
      while (c < n && s_dv[c]) c++;
      e = c - 1;
      L = e - s + 1;
      if (s == 0) continue;
      i = 0;
      while (i < L && i < MAX_PRE && s_d[s+i] == 8'h55 && !s_er[s+i]) i++;
      if (i == L) continue;
      t = s + i;
      if (s_d[t] != 8'hD5 || s_er[t] || i < MIN_PRE) begin ev_a[t] = 1; continue; end
      nb = L - i - 1;
      m = nb > MAX_LEN ? MAX_LEN : nb;
      ec = t + 1 + m;
      bad = nb > MAX_LEN || nb < MIN_LEN;
      for (int j = 0; j < m; j++) bad |= s_er[t+1+j];
      for (int k = t; k <= ec; k++) e_en[k] = 1;
      for (int j = 0; j < m; j++) begin
        e_val[t+2+j] = 1; e_dat[t+2+j] = s_d[t+1+j]; e_sof[t+2+j] = (j == 0);
      end
      e_eof[ec] = 1; e_err[ec] = bad; e_len[ec] = 16'(m);
      if (bad) ev_b[ec] = 1; else ev_g[ec] = 1;
    end
    cur = 0; g = 0; b = 0; a = 0;
    for (int k = 0; k < MAXN + 2; k++) begin
      if (e_val[k]) cur = e_dat[k];
      e_dat[k] = cur;
      if (ev_g[k] && g < SMAX) g++;
      if (ev_b[k] && b < SMAX) b++;
      if (ev_a[k] && a < SMAX) a++;
      e_sg[k] = g; e_sb[k] = b; e_sa[k] = a;
    end
  endtask
  task automatic lit(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic logic [63:0] pack(input logic en, input logic v, input logic so, input logic eo,
      input logic er, input logic [7:0] d, input logic [15:0] len, input logic [CW-1:0] g,
      input logic [CW-1:0] b, input logic [CW-1:0] a);
    return 64'({en, v, so, eo, er, d, len, g, b, a});
  endfunction
  task automatic compare(input int c);
    logic [63:0] act, exp;
    act = pack(bus.rx_en, bus.rx_data_valid, bus.rx_sof, bus.rx_eof, bus.rx_err, bus.rx_data,
               e_eof[c] ? bus.frame_len : 16'd0, bus.stat_good, bus.stat_bad, bus.stat_align_err);
    exp = pack(e_en[c], e_val[c], e_sof[c], e_eof[c], e_err[c], e_dat[c], e_len[c],
               CW'(e_sg[c]), CW'(e_sb[c]), CW'(e_sa[c]));
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL outputs cycle %0d: got %h expected %h (en,val,sof,eof,err,data,len,good,bad,align)",
               c, act, exp);
    end
    if (bus.rx_data_valid) obs_val++;
    if (bus.rx_eof) begin
      obs_eof++; obs_len = int'(bus.frame_len); obs_err = bus.rx_err; obs_eof_dat = bus.rx_data;
    end
  endtask
  task automatic run(input int ncyc);
    model();
    obs_val = 0; obs_eof = 0; obs_len = -1; obs_err = 1'bx; obs_eof_dat = 8'h00;
    for (int c = 0; c < ncyc; c++) begin
      bus.phy_rx_dv = s_dv[c]; bus.phy_rxd = s_d[c]; bus.phy_rx_er = s_er[c];
      @(posedge clk);
      @(negedge clk);
      compare(c);
    end
  endtask
  task automatic zero_check(input string nm);
    lit(nm, int'(pack(bus.rx_en, bus.rx_data_valid, bus.rx_sof, bus.rx_eof, bus.rx_err, bus.rx_data,
                      bus.frame_len, bus.stat_good, bus.stat_bad, bus.stat_align_err) != 0), 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.phy_rx_dv = 1'b0; bus.phy_rxd = 8'h00; bus.phy_rx_er = 1'b0;
    repeat (2) @(negedge clk);
    zero_check("reset_outputs_zero");
    rst_n = 1'b1;
    n = 0;
  endtask
  task automatic random_segment();
    int npre, len, k;
    while (n < MAXN - 300) begin
      npre = $urandom_range(0, 9);
      k = $urandom_range(0, 9);
      len = k < 2 ? $urandom_range(0, 3) : k < 4 ? $urandom_range(62, 66) : $urandom_range(5, 200);
      for (int i = 0; i < npre; i++)
        push(1'b1, ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'h55, $urandom_range(0, 40) == 0);
      if ($urandom_range(0, 12) != 0) begin
        push(1'b1, ($urandom_range(0, 10) == 0) ? 8'($urandom) : 8'hD5, $urandom_range(0, 60) == 0);
        for (int j = 0; j < len; j++) push(1'b1, 8'($urandom), $urandom_range(0, 150) == 0);
      end
      idle($urandom_range(1, 3));
    end
  endtask
  initial begin
    bus.phy_rx_dv = 1'b0; bus.phy_rxd = 8'h00; bus.phy_rx_er = 1'b0;
    #1 zero_check("power_on_reset_zero");
    // 7x55, D5, 64 bytes 00..3F
    do_reset();
    idle(2); frame(7, 64, -1, 1'b0);
    run(n);
    lit("good64_valid_bytes", obs_val, 64);
    lit("good64_frame_len", obs_len, 64);
    lit("good64_rx_err", int'(obs_err), 0);
    lit("good64_last_byte", int'(obs_eof_dat), 8'h3F);
    lit("good64_stat_good", int'(bus.stat_good), 1);
    // runt, over-long preamble, bad preamble byte, clean frame, er mid-frame
    do_reset();
    idle(2); frame(1, 10, -1, 1'b0);
    for (int i = 0; i < 8; i++) push(1'b1, 8'h55, 1'b0);
    push(1'b1, 8'hD5, 1'b0);
    for (int j = 0; j < 5; j++) push(1'b1, 8'(j), 1'b0);
    idle(1);
    push(1'b1, 8'h55, 1'b0); push(1'b1, 8'h55, 1'b0); push(1'b1, 8'hAA, 1'b0); push(1'b1, 8'hD5, 1'b0);
    for (int j = 0; j < 5; j++) push(1'b1, 8'(j), 1'b0);
    idle(1);
    frame(3, 70, -1, 1'b1);
    frame(7, 64, 20, 1'b0);
    run(n);
    lit("mix_valid_bytes", obs_val, 144);
    lit("mix_stat_good", int'(bus.stat_good), 1);
    lit("mix_stat_bad", int'(bus.stat_bad), 2);
    lit("mix_stat_align", int'(bus.stat_align_err), 2);
    // oversize, recovery, exact max length, 1-byte and empty frames
    do_reset();
    idle(2); frame(7, 1600, -1, 1'b1); frame(7, 64, -1, 1'b0);
    frame(7, 1518, -1, 1'b1); frame(2, 1, -1, 1'b0); frame(2, 0, -1, 1'b0);
    run(n);
    lit("len_valid_bytes", obs_val, 3101);
    lit("len_eof_count", obs_eof, 5);
    lit("len_stat_good", int'(bus.stat_good), 2);
    lit("len_stat_bad", int'(bus.stat_bad), 3);
    lit("len_stat_align", int'(bus.stat_align_err), 0);
    // asynchronous reset in the middle of a payload, released with dv high
    do_reset();
    idle(2); frame(7, 64, -1, 1'b0); frame(7, 200, -1, 1'b1);
    run(133);
    lit("midrst_rx_en_before", int'(bus.rx_en), 1);
    lit("midrst_good_before", int'(bus.stat_good), 1);
    #2 rst_n = 1'b0;
    #1 zero_check("midrst_outputs_zero");
    repeat (2) @(negedge clk);
    n = 0;
    for (int j = 0; j < 20; j++) push(1'b1, 8'($urandom), 1'b0);
    idle(1); frame(7, 64, -1, 1'b0);
    rst_n = 1'b1;
    run(n);
    lit("midrst_eof_count", obs_eof, 1);
    lit("midrst_stat_good", int'(bus.stat_good), 1);
    // saturation of all three counters
    do_reset();
    idle(2);
    for (int i = 0; i < 20; i++) begin push(1'b1, 8'hAA, 1'b0); idle(1); end
    for (int i = 0; i < 17; i++) frame(1, 64, -1, 1'b1);
    for (int i = 0; i < 17; i++) frame(7, 5, -1, 1'b1);
    run(n);
    lit("sat_stat_align", int'(bus.stat_align_err), SMAX);
    lit("sat_stat_good", int'(bus.stat_good), SMAX);
    lit("sat_stat_bad", int'(bus.stat_bad), SMAX);
    for (int r = 0; r < 4; r++) begin
      do_reset();
      idle(2);
      random_segment();
      run(n);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
